// File: rtl/sys_out_sched.sv
// Write-back sequencer for the systolic array sys_out DPR: gates ag_o/DPR writes, then streams read addresses.
// Optional SYS_OUT_SCHED_PERF_EN adds stall_cnt and last_job_cycles outputs.
module sys_out_sched #(
  parameter int unsigned FEATURE_BITS = 4,
  parameter int unsigned M            = 9,
  parameter int unsigned GAMMA        = 3,
  parameter int unsigned TILE_BITS    = 4
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [TILE_BITS-1:0]    job_tiles,
  input  logic                    arr_valid,
  output logic                    ag_start,
  output logic                    dpr_we,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [FEATURE_BITS-1:0] rd_addr,
  output logic                    busy,
  output logic                    job_done,
  output logic                    err_ovf
`ifdef SYS_OUT_SCHED_PERF_EN
  ,
  output logic [15:0]             stall_cnt,
  output logic [15:0]             last_job_cycles
`endif
);

  localparam int unsigned BW = 2 * FEATURE_BITS;
  localparam logic [BW-1:0] LAST_BEAT = BW'(M * GAMMA - 1);
  localparam logic [FEATURE_BITS-1:0] LAST_ADDR = FEATURE_BITS'(M - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              r_state;
  logic [BW-1:0]           r_beat_cnt;
  logic [TILE_BITS-1:0]    r_tiles_left;
  logic [FEATURE_BITS-1:0] r_rd_addr;
  logic                    r_err_ovf;

  logic w_accept;
  logic w_beat;
  logic w_tile_end;
  logic w_rd_fire;
  logic w_rd_last;

  always_comb begin
    w_accept   = job_valid & (r_state == S_IDLE);
    w_beat     = arr_valid & (r_state == S_WRITE);
    w_tile_end = w_beat & (r_beat_cnt == LAST_BEAT);
    w_rd_fire  = rd_ready & (r_state == S_READ);
    w_rd_last  = w_rd_fire & (r_rd_addr == LAST_ADDR);
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_beat_cnt   <= '0;
      r_tiles_left <= '0;
      r_rd_addr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tiles_left <= job_tiles;
            r_beat_cnt   <= '0;
            r_state      <= (job_tiles == '0) ? S_DONE : S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_tile_end) begin
            r_beat_cnt   <= '0;
            r_tiles_left <= r_tiles_left - TILE_BITS'(1);
            if (r_tiles_left == TILE_BITS'(1)) begin
              r_rd_addr <= '0;
              r_state   <= S_READ;
            end
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
          end
        end
        S_READ: begin
          if (w_rd_last) begin
            r_rd_addr <= '0;
            r_state   <= S_DONE;
          end else if (w_rd_fire) begin
            r_rd_addr <= r_rd_addr + FEATURE_BITS'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Accept clears the sticky flag; this takes priority over a stray arr_valid in the same cycle.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_ovf <= 1'b0;
    end else if (w_accept) begin
      r_err_ovf <= 1'b0;
    end else if (arr_valid && (r_state != S_WRITE)) begin
      r_err_ovf <= 1'b1;
    end
  end

  always_comb begin
    job_ready = (r_state == S_IDLE);
    ag_start  = w_beat;
    dpr_we    = w_beat;
    rd_valid  = (r_state == S_READ);
    rd_addr   = r_rd_addr;
    busy      = (r_state != S_IDLE);
    job_done  = (r_state == S_DONE);
    err_ovf   = r_err_ovf;
  end

`ifdef SYS_OUT_SCHED_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_job_cyc;
  logic [15:0] r_last_cyc;
  logic        w_stall;

  always_comb begin
    w_stall = ((r_state == S_WRITE) & ~arr_valid) | ((r_state == S_READ) & ~rd_ready);
  end

  // r_job_cyc counts cycles after accept; the DONE cycle is folded in when latching.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_job_cyc   <= '0;
      r_last_cyc  <= '0;
    end else begin
      if (w_accept) begin
        r_stall_cnt <= '0;
        r_job_cyc   <= '0;
      end else begin
        if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 16'd1;
        if ((r_state != S_IDLE) && (r_job_cyc != '1)) r_job_cyc <= r_job_cyc + 16'd1;
      end
      if (r_state == S_DONE) begin
        r_last_cyc <= (r_job_cyc != '1) ? r_job_cyc + 16'd1 : r_job_cyc;
      end
    end
  end

  always_comb begin
    stall_cnt       = r_stall_cnt;
    last_job_cycles = r_last_cyc;
  end
`endif

endmodule

// File: tb/tb_sys_out_sched.sv
// Self-checking bench for sys_out_sched: vector table for idle/error/ignore cases, sequences for full jobs.
module tb_sys_out_sched;

  logic       sys_clk;
  logic       reset_n;
  logic       job_valid;
  logic       job_ready;
  logic [3:0] job_tiles;
  logic       arr_valid;
  logic       ag_start;
  logic       dpr_we;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] rd_addr;
  logic       busy;
  logic       job_done;
  logic       err_ovf;

  int n_checks;
  int n_errors;

  sys_out_sched #(
    .FEATURE_BITS(4),
    .M(9),
    .GAMMA(3),
    .TILE_BITS(4)
  ) dut (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_tiles(job_tiles),
    .arr_valid(arr_valid),
    .ag_start (ag_start),
    .dpr_we   (dpr_we),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_addr  (rd_addr),
    .busy     (busy),
    .job_done (job_done),
    .err_ovf  (err_ovf)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       jv;
    logic [3:0] jt;
    logic       av;
    logic       rr;
    logic       jr;
    logic       bz;
    logic       ag;
    logic       we;
    logic       rv;
    logic       jd;
    logic       er;
  } vec_t;

  vec_t tbl[10];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk1({tag, "_job_ready"}, job_ready, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_ag_start"}, ag_start, 1'b0);
    chk1({tag, "_dpr_we"}, dpr_we, 1'b0);
    chk1({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk1({tag, "_job_done"}, job_done, 1'b0);
    chk1({tag, "_err_ovf"}, err_ovf, 1'b0);
    chki({tag, "_rd_addr"}, int'(rd_addr), 0);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    job_valid = 1'b0;
    arr_valid = 1'b0;
    rd_ready  = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk_idle_outputs("rst");
    repeat (2) @(negedge sys_clk);
    #1 reset_n = 1'b1;
  endtask

  // One full job: accept, write phase (arr_valid always high or toggling), read phase with an optional stall.
  task automatic run_job(input string tag, input logic [3:0] tiles, input bit toggle,
                         input int stall_at, input int stall_len);
    int total, beats, we_cnt, addr, stalls, run, max_run;
    total   = int'(tiles) * 27;
    beats   = 0;
    we_cnt  = 0;
    run     = 0;
    max_run = 0;
    @(negedge sys_clk);
    job_valid = 1'b1;
    job_tiles = tiles;
    arr_valid = 1'b0;
    rd_ready  = 1'b0;
    #1 chk1({tag, "_accept_ready"}, job_ready, 1'b1);
    for (int c = 0; c < 600 && beats < total; c++) begin
      @(negedge sys_clk);
      job_valid = 1'b0;
      arr_valid = toggle ? ((c % 2) == 0) : 1'b1;
      #1;
      chk1({tag, "_w_dpr_we"}, dpr_we, arr_valid);
      chk1({tag, "_w_ag_start"}, ag_start, arr_valid);
      chk1({tag, "_w_rd_valid"}, rd_valid, 1'b0);
      chk1({tag, "_w_busy"}, busy, 1'b1);
      if (dpr_we) begin
        we_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (arr_valid) beats++;
    end
    chki({tag, "_beats_sent"}, beats, total);
    chki({tag, "_we_pulses"}, we_cnt, total);
    if (!toggle) chki({tag, "_we_run"}, max_run, total);
    addr   = 0;
    stalls = 0;
    for (int c = 0; c < 100 && addr < 9; c++) begin
      @(negedge sys_clk);
      arr_valid = 1'b0;
      rd_ready  = !((addr == stall_at) && (stalls < stall_len));
      #1;
      chk1({tag, "_r_rd_valid"}, rd_valid, 1'b1);
      chki({tag, "_r_rd_addr"}, int'(rd_addr), addr);
      chk1({tag, "_r_dpr_we"}, dpr_we, 1'b0);
      chk1({tag, "_r_job_done"}, job_done, 1'b0);
      if (rd_ready) addr++;
      else stalls++;
    end
    chki({tag, "_addrs_read"}, addr, 9);
    if (stall_at >= 0) chki({tag, "_stall_cycles"}, stalls, stall_len);
    @(negedge sys_clk);
    rd_ready = 1'b0;
    #1;
    chk1({tag, "_done_pulse"}, job_done, 1'b1);
    chk1({tag, "_done_busy"}, busy, 1'b1);
    chk1({tag, "_done_rd_valid"}, rd_valid, 1'b0);
    chk1({tag, "_done_ready"}, job_ready, 1'b0);
    @(negedge sys_clk);
    #1;
    chk1({tag, "_after_done"}, job_done, 1'b0);
    chk1({tag, "_after_busy"}, busy, 1'b0);
    chk1({tag, "_after_ready"}, job_ready, 1'b1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    job_valid = 1'b0;
    job_tiles = 4'd0;
    arr_valid = 1'b0;
    rd_ready  = 1'b0;

    //            jv    jt    av    rr    jr    bz    ag    we    rv    jd    er
    tbl[0] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge sys_clk);
    #1 chk_idle_outputs("in_reset");
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      job_valid = tbl[i].jv;
      job_tiles = tbl[i].jt;
      arr_valid = tbl[i].av;
      rd_ready  = tbl[i].rr;
      #1;
      chk1($sformatf("v%0d_job_ready", i), job_ready, tbl[i].jr);
      chk1($sformatf("v%0d_busy", i), busy, tbl[i].bz);
      chk1($sformatf("v%0d_ag_start", i), ag_start, tbl[i].ag);
      chk1($sformatf("v%0d_dpr_we", i), dpr_we, tbl[i].we);
      chk1($sformatf("v%0d_rd_valid", i), rd_valid, tbl[i].rv);
      chk1($sformatf("v%0d_job_done", i), job_done, tbl[i].jd);
      chk1($sformatf("v%0d_err_ovf", i), err_ovf, tbl[i].er);
    end
    do_reset();

    run_job("t1", 4'd1, 1'b0, -1, 0);
    run_job("t2", 4'd3, 1'b1, -1, 0);
    run_job("t3", 4'd1, 1'b0, 4, 5);

    // Reset during WRITE at beat 13 of the second tile.
    @(negedge sys_clk);
    job_valid = 1'b1;
    job_tiles = 4'd2;
    @(negedge sys_clk);
    job_valid = 1'b0;
    arr_valid = 1'b1;
    repeat (40) @(negedge sys_clk);
    #1 chk1("t6_pre_ag_start", ag_start, 1'b1);
    #1 reset_n = 1'b0;
    #1 chk_idle_outputs("t6_async");
    arr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      #1 chk1("t6_no_done_rst", job_done, 1'b0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      #1 chk1("t6_no_done_after", job_done, 1'b0);
      chk1("t6_idle_busy", busy, 1'b0);
    end
    run_job("t6", 4'd1, 1'b0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
